c17_response_checker: RTL and testbench

- Sequential response analyzer for the c17 benchmark core; the receiving end of the c17 stimulus stream.
- Accepts each applied input pattern together with the response observed on N22/N23, and compares it against an internal golden c17 model.
- Counts mismatches, captures the first failing vector and compacts all observed responses into a MISR signature.
- Sits between the c17 instance (or a locked/trojan-inserted variant) and the test controller; gives an on-chip pass/fail verdict after a programmed number of patterns.

---
 rtl/c17_response_checker.sv | 88 ++++++++
 tb/tb_c17_response_checker.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/c17_response_checker.sv
// c17_response_checker: compares observed c17 responses to a golden model, counts errors, captures first failure, compacts into a MISR.
module c17_response_checker #(
  parameter int NUM_PATTERNS = 32,
  parameter int CNT_W = 6,
  parameter int MISR_W = 16,
  parameter logic [MISR_W-1:0] MISR_POLY = 16'h1021,
  parameter logic [MISR_W-1:0] MISR_SEED = 16'hFFFF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              pat_valid,
  input  logic [4:0]        pat_in,
  input  logic [1:0]        resp_in,
  output logic              ready,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [CNT_W-1:0]  pat_count,
  output logic [CNT_W-1:0]  err_count,
  output logic              first_fail_valid,
  output logic [4:0]        first_fail_pat,
  output logic [1:0]        first_fail_resp,
  output logic [MISR_W-1:0] signature
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state;
  logic n10, n11, n16, n19, mis, acc, last;
  logic [1:0] exp_resp;
  logic [CNT_W-1:0] err_nxt;
  logic [MISR_W-1:0] sig_nxt;
  always_comb begin
    n10 = ~(pat_in[4] & pat_in[2]);
    n11 = ~(pat_in[2] & pat_in[1]);
    n16 = ~(pat_in[3] & n11);
    n19 = ~(n11 & pat_in[0]);
    exp_resp = {~(n10 & n16), ~(n16 & n19)};
    mis = resp_in != exp_resp;
    acc = pat_valid && state == RUN;
    last = pat_count == CNT_W'(NUM_PATTERNS - 1);
    err_nxt = (mis && err_count != '1) ? err_count + CNT_W'(1) : err_count;
    sig_nxt = {signature[MISR_W-2:0], 1'b0} ^ (signature[MISR_W-1] ? MISR_POLY : '0)
            ^ {{(MISR_W-2){1'b0}}, resp_in};
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      ready <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      pass <= 1'b0;
      pat_count <= '0;
      err_count <= '0;
      first_fail_valid <= 1'b0;
      first_fail_pat <= '0;
      first_fail_resp <= '0;
      signature <= MISR_SEED;
    end else if (state != RUN && start) begin
      state <= RUN;
      ready <= 1'b1;
      busy <= 1'b1;
      done <= 1'b0;
      pass <= 1'b0;
      pat_count <= '0;
      err_count <= '0;
      first_fail_valid <= 1'b0;
      first_fail_pat <= '0;
      first_fail_resp <= '0;
      signature <= MISR_SEED;
    end else if (acc) begin
      pat_count <= pat_count + CNT_W'(1);
      err_count <= err_nxt;
      signature <= sig_nxt;
      if (mis && !first_fail_valid) begin
        first_fail_valid <= 1'b1;
        first_fail_pat <= pat_in;
        first_fail_resp <= resp_in;
      end
      if (last) begin
        state <= DONE;
        ready <= 1'b0;
        busy <= 1'b0;
        done <= 1'b1;
        pass <= err_nxt == '0;
      end
    end
  end
endmodule

// File: tb/tb_c17_response_checker.sv
// tb_c17_response_checker: directed checks of the c17 response checker against an independent c17/MISR model.
module tb_c17_response_checker;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, pat_valid = 1'b0;
  logic [4:0] pat_in = '0;
  logic [1:0] resp_in = '0;
  logic ready, busy, done, pass, first_fail_valid;
  logic [5:0] pat_count, err_count;
  logic [4:0] first_fail_pat;
  logic [1:0] first_fail_resp;
  logic [15:0] signature, exp_sig, gsig;
  int n_assert = 0, n_fail = 0;

  c17_response_checker dut (
    .clk(clk), .rst(rst), .start(start), .pat_valid(pat_valid), .pat_in(pat_in),
    .resp_in(resp_in), .ready(ready), .busy(busy), .done(done), .pass(pass),
    .pat_count(pat_count), .err_count(err_count), .first_fail_valid(first_fail_valid),
    .first_fail_pat(first_fail_pat), .first_fail_resp(first_fail_resp), .signature(signature)
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] gold(input logic [4:0] p);
    logic a, b, c, d;
    a = !(p[4] && p[2]);
    b = !(p[2] && p[1]);
    c = !(p[3] && b);
    d = !(b && p[0]);
    return {!(a && c), !(c && d)};
  endfunction

  function automatic logic [15:0] misr(input logic [15:0] s, input logic [1:0] r);
    logic [15:0] t;
    t = s << 1;
    if (s[15]) t = t ^ 16'h1021;
    return t ^ {14'd0, r};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic send(input logic [4:0] p, input logic [1:0] r);
    pat_valid = 1'b1;
    pat_in = p;
    resp_in = r;
    exp_sig = misr(exp_sig, r);
    @(negedge clk);
    pat_valid = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    exp_sig = 16'hFFFF;
  endtask

  task automatic run(input int bad1, input logic [1:0] r1, input int bad2, input logic [1:0] r2, input bit gaps);
    for (int i = 0; i < 32; i++) begin
      send(5'(i), i == bad1 ? r1 : i == bad2 ? r2 : gold(5'(i)));
      if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
      if (i == 30) chk("not_done_before_last", {done, busy}, 2'b01);
    end
  endtask

  initial begin
    exp_sig = 16'hFFFF;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_sig", signature, 16'hFFFF);
    chk("rst_flags", {ready, busy, done, pass, first_fail_valid}, 5'b0);
    chk("rst_counts", {pat_count, err_count}, 12'd0);
    chk("gold_00000", gold(5'b00000), 2'b00);
    chk("gold_00100", gold(5'b00100), 2'b00);
    chk("gold_11111", gold(5'b11111), 2'b10);
    pat_valid = 1'b1; pat_in = 5'd3; resp_in = 2'b11;
    repeat (2) @(negedge clk);
    pat_valid = 1'b0;
    chk("idle_valid_cnt", pat_count, 0);
    chk("idle_valid_sig", signature, 16'hFFFF);
    do_start();
    chk("run_ready_busy", {ready, busy, done}, 3'b110);
    for (int i = 0; i < 3; i++) send(5'(i), 2'b01);
    chk("pre_rst_cnt", pat_count, 3);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_cnt", pat_count, 0);
    chk("async_rst_sig", signature, 16'hFFFF);
    chk("async_rst_flags", {ready, busy, done}, 3'b000);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    do_start();
    run(-1, 2'b00, -1, 2'b00, 1'b0);
    gsig = exp_sig;
    chk("golden_flags", {done, pass, busy, ready, first_fail_valid}, 5'b11000);
    chk("golden_counts", {pat_count, err_count}, {6'd32, 6'd0});
    chk("golden_sig", signature, gsig);
    pat_valid = 1'b1; pat_in = 5'd7; resp_in = 2'b11;
    repeat (3) @(negedge clk);
    pat_valid = 1'b0;
    chk("done_valid_cnt", pat_count, 32);
    chk("done_valid_sig", signature, gsig);
    chk("done_hold", {done, pass}, 2'b11);
    do_start();
    run(31, 2'b00, -1, 2'b00, 1'b0);
    chk("single_flags", {done, pass, first_fail_valid}, 3'b101);
    chk("single_err", err_count, 1);
    chk("single_ff", {first_fail_pat, first_fail_resp}, {5'b11111, 2'b00});
    chk("single_sig", signature, exp_sig);
    do_start();
    run(4, 2'b11, 31, 2'b00, 1'b0);
    chk("multi_err", err_count, 2);
    chk("multi_ff", {first_fail_pat, first_fail_resp}, {5'b00100, 2'b11});
    chk("multi_pass", {done, pass}, 2'b10);
    chk("multi_sig", signature, exp_sig);
    n_assert++;
    assert (signature !== gsig) else begin
      n_fail++;
      $error("FAIL multi_sig_differs observed=%h expected!=%h", signature, gsig);
    end
    do_start();
    for (int i = 0; i < 11; i++) send(5'(i), gold(5'(i)));
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_in_run_ignored", {pat_count, busy}, {6'd11, 1'b1});
    for (int i = 11; i < 32; i++) begin
      send(5'(i), gold(5'(i)));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    chk("gaps_sig", signature, gsig);
    chk("gaps_flags", {done, pass, pat_count}, {2'b11, 6'd32});
    do_start();
    for (int i = 0; i < 10; i++) send(5'(i), gold(5'(i)));
    chk("midrun_cnt", pat_count, 10);
    rst = 1'b1;
    #1;
    chk("midrun_rst", {pat_count, busy, done, pass}, 9'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    do_start();
    run(-1, 2'b00, -1, 2'b00, 1'b0);
    chk("rerun_pass", {done, pass, err_count}, {2'b11, 6'd0});
    chk("rerun_sig", signature, gsig);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
